// File: rtl/fetch_unit.sv
// fetch_unit: multicycle instruction fetch stage with PC, memory handshake and retire counter
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        jump,
    input  logic        pcsrc,
    input  logic        retire,
    output logic [31:0] icount
);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t state;
    logic [31:0] nextpc;
    assign imem_addr = pc;
    assign pcplus4   = pc + 32'd4;
    assign op        = instr[31:26];
    assign imem_req  = (state == FETCH) & ~reset;
    // next pc: jump beats taken branch, otherwise sequential
    always_comb begin
        nextpc = jump  ? {pcplus4[31:28], instr[25:0], 2'b00} :
                 pcsrc ? pcplus4 + {{14{instr[15]}}, instr[15:0], 2'b00} : pcplus4;
    end
    // fetch/exec sequencing: accept one word per request, advance pc on retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            instr_valid <= 1'b0;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            icount      <= 32'h0;
        end else if (state == FETCH) begin
            if (imem_ready) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
                state       <= EXEC;
            end
        end else if (retire) begin
            pc          <= nextpc;
            icount      <= icount + 32'd1;
            instr_valid <= 1'b0;
            state       <= FETCH;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch handshake, next-pc selection, stalls, wrap and reset
module tb_fetch_unit;
    logic        clk, reset, imem_ready, jump, pcsrc, retire;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pcplus4, icount;
    logic [5:0]  op;
    int checks = 0;
    int passes = 0;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .op(op),
        .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4), .jump(jump),
        .pcsrc(pcsrc), .retire(retire), .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] w);
        imem_ready = 1'b1;
        imem_rdata = w;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic do_retire(input logic j, input logic s);
        retire = 1'b1;
        jump   = j;
        pcsrc  = s;
        tick();
        retire = 1'b0;
        jump   = 1'b0;
        pcsrc  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else passes++;
        checks++; if (pc !== 32'h0) $display("FAIL rst_pc got %h want 0", pc); else passes++;
        checks++; if (icount !== 32'h0) $display("FAIL rst_icount got %h want 0", icount); else passes++;
        checks++; if (op !== 6'h0 || instr_valid !== 1'b0) $display("FAIL rst_op_valid got %h/%b want 00/0", op, instr_valid); else passes++;
        reset = 1'b0;
        imem_rdata = 32'h8C08_0004;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req got %b/%h want 1/0", imem_req, imem_addr); else passes++;
        tick();
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1) $display("FAIL first_valid got %b want 1", instr_valid); else passes++;
        checks++; if (op !== 6'b100011) $display("FAIL first_op got %b want 100011", op); else passes++;
        checks++; if (imem_req !== 1'b0) $display("FAIL exec_req got %b want 0", imem_req); else passes++;
        do_retire(1'b0, 1'b0);
        checks++; if (pc !== 32'h4 || icount !== 32'd1) $display("FAIL seq_retire got %h/%0d want 00000004/1", pc, icount); else passes++;
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) $display("FAIL back_to_fetch got %b/%b want 1/0", imem_req, instr_valid); else passes++;
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0);
            do_retire(1'b0, 1'b0);
        end
        checks++; if (pc !== 32'h10 || icount !== 32'd4) $display("FAIL reach_10 got %h/%0d want 00000010/4", pc, icount); else passes++;
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0)
                $display("FAIL wait_%0d got %b/%h/%b want 1/00000010/0", i, imem_req, imem_addr, instr_valid); else passes++;
            tick();
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h1000_FFFE;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL wait_last got %b/%h want 1/00000010", imem_req, imem_addr); else passes++;
        tick();
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1000_FFFE) $display("FAIL wait_accept got %b/%h want 1/1000fffe", instr_valid, instr); else passes++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            imem_ready = i[0];
            imem_rdata = 32'hA5A5_0000 + i;
            jump = 1'b1;
            pcsrc = 1'b1;
            tick();
            checks++; if (pc !== 32'h10 || instr !== 32'h1000_FFFE || icount !== 32'd4 || instr_valid !== 1'b1 || imem_req !== 1'b0)
                $display("FAIL stall_%0d got pc=%h instr=%h icount=%0d valid=%b req=%b want 00000010/1000fffe/4/1/0", i, pc, instr, icount, instr_valid, imem_req); else passes++;
        end
        imem_ready = 1'b0;
        do_retire(1'b0, 1'b0);
        checks++; if (pc !== 32'h14 || icount !== 32'd5) $display("FAIL stall_retire got %h/%0d want 00000014/5", pc, icount); else passes++;
    endtask

    task automatic test_branch();
        retire = 1'b1;
        jump = 1'b1;
        imem_ready = 1'b0;
        tick();
        retire = 1'b0;
        jump = 1'b0;
        checks++; if (pc !== 32'h14 || icount !== 32'd5 || imem_req !== 1'b1) $display("FAIL fetch_ignores_retire got %h/%0d/%b want 00000014/5/1", pc, icount, imem_req); else passes++;
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0);
            do_retire(1'b0, 1'b0);
        end
        checks++; if (pc !== 32'h20) $display("FAIL reach_20 got %h want 00000020", pc); else passes++;
        do_fetch(32'h1000_FFFE);
        do_retire(1'b0, 1'b1);
        checks++; if (pc !== 32'h1C || icount !== 32'd9) $display("FAIL branch_back got %h/%0d want 0000001c/9", pc, icount); else passes++;
        do_fetch(32'h1000_0003);
        do_retire(1'b0, 1'b1);
        checks++; if (pc !== 32'h2C) $display("FAIL branch_fwd got %h want 0000002c", pc); else passes++;
        do_fetch(32'h1000_0003);
        do_retire(1'b0, 1'b0);
        checks++; if (pc !== 32'h30) $display("FAIL branch_not_taken got %h want 00000030", pc); else passes++;
    endtask

    task automatic test_jump();
        force dut.pc = 32'h4000_0000;
        #1;
        release dut.pc;
        checks++; if (imem_addr !== 32'h4000_0000) $display("FAIL jump_setup got %h want 40000000", imem_addr); else passes++;
        do_fetch(32'h0800_0010);
        do_retire(1'b1, 1'b0);
        checks++; if (pc !== 32'h4000_0040) $display("FAIL jump got %h want 40000040", pc); else passes++;
        do_fetch(32'h0800_0100);
        do_retire(1'b1, 1'b1);
        checks++; if (pc !== 32'h4000_0400) $display("FAIL jump_priority got %h want 40000400", pc); else passes++;
    endtask

    task automatic test_wrap();
        force dut.pc = 32'hFFFF_FFFC;
        #1;
        release dut.pc;
        checks++; if (pcplus4 !== 32'h0) $display("FAIL pcplus4_wrap got %h want 0", pcplus4); else passes++;
        do_fetch(32'h0);
        do_retire(1'b0, 1'b0);
        checks++; if (pc !== 32'h0) $display("FAIL pc_wrap got %h want 0", pc); else passes++;
        force dut.icount = 32'hFFFF_FFFF;
        #1;
        release dut.icount;
        do_fetch(32'h0);
        do_retire(1'b0, 1'b0);
        checks++; if (icount !== 32'h0 || pc !== 32'h4) $display("FAIL icount_wrap got %h/%h want 0/00000004", icount, pc); else passes++;
    endtask

    task automatic test_async_reset();
        imem_ready = 1'b0;
        #2;
        reset = 1'b1;
        imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || icount !== 32'h0 || instr_valid !== 1'b0)
            $display("FAIL async_fetch got req=%b pc=%h icount=%h valid=%b want 0/0/0/0", imem_req, pc, icount, instr_valid); else passes++;
        tick();
        reset = 1'b0;
        imem_ready = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) $display("FAIL restart got %b/%h/%b want 1/0/0", imem_req, imem_addr, instr_valid); else passes++;
        do_fetch(32'h0);
        do_retire(1'b0, 1'b0);
        do_fetch(32'hFC00_0000);
        checks++; if (instr_valid !== 1'b1 || icount !== 32'd1 || op !== 6'h3F) $display("FAIL pre_exec_reset got %b/%0d/%h want 1/1/3f", instr_valid, icount, op); else passes++;
        retire = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || icount !== 32'h0 || instr !== 32'h0 || pc !== 32'h0)
            $display("FAIL async_exec got valid=%b icount=%h instr=%h pc=%h want 0/0/0/0", instr_valid, icount, instr, pc); else passes++;
        tick();
        retire = 1'b0;
        reset = 1'b0;
        imem_rdata = 32'h8C08_0004;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1 || op !== 6'b100011 || icount !== 32'h0) $display("FAIL post_reset_fetch got %b/%b/%0d want 1/100011/0", instr_valid, op, icount); else passes++;
    endtask

    initial begin
        reset = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        jump = 1'b0;
        pcsrc = 1'b0;
        retire = 1'b0;
        test_reset();
        test_wait_states();
        test_stall();
        test_branch();
        test_jump();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
